// File: rtl/dmem_wbuf_if.sv
// dmem_itf: single-outstanding request/response data-memory interface.
// The mst side drives requests and the slv side answers them.
interface dmem_itf;
  logic [31:0] addr;
  logic [3:0]  rmask;
  logic [3:0]  wmask;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        resp;

  modport mst (output addr, output rmask, output wmask, output wdata,
               input  rdata, input  resp);
  modport slv (input  addr, input  rmask, input  wmask, input  wdata,
               output rdata, output resp);
endinterface

// File: rtl/dmem_wbuf.sv
// dmem_wbuf: posted store buffer between the data TCM and the cache/arbiter.
// Define WBUF_COALESCE_EN to merge a store into the youngest entry of the same word.
module dmem_wbuf #(
  parameter int DEPTH = 4
) (
  input logic  clk,
  input logic  rst,
  dmem_itf.slv slv_itf,
  dmem_itf.mst mst_itf
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {D_IDLE, D_WR, D_RD} dstate_e;

  dstate_e state_q, state_d;

  logic [29:0]   ent_addr [DEPTH];
  logic [3:0]    ent_mask [DEPTH];
  logic [31:0]   ent_data [DEPTH];
  logic [PW-1:0] head_q, tail_q, offs;
  logic [CW-1:0] count_q;

  logic        rd_pend_q;
  logic [31:0] rd_addr_q;
  logic [3:0]  rd_mask_q;
  logic        hw_valid_q;
  logic [29:0] hw_addr_q;
  logic [3:0]  hw_mask_q;
  logic [31:0] hw_data_q;
  logic        ack_q;
  logic [31:0] mst_addr_q, mst_wdata_q;
  logic [3:0]  mst_rmask_q, mst_wmask_q;

  logic        in_rd, in_wr, full, empty;
  logic        ld_active, ld_match, merge, pop, push_in, push_hw, hold_in;
  logic        issue_rd, issue_wr;
  logic [31:0] ld_addr;
  logic [29:0] ld_word;
  logic [3:0]  ld_mask;
  logic [29:0] iss_addr;
  logic [3:0]  iss_mask;
  logic [31:0] iss_data;

  assign in_rd     = |slv_itf.rmask;
  assign in_wr     = |slv_itf.wmask;
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign ld_active = rd_pend_q || in_rd;
  assign ld_addr   = rd_pend_q ? rd_addr_q : slv_itf.addr;
  assign ld_mask   = rd_pend_q ? rd_mask_q : slv_itf.rmask;
  assign ld_word   = ld_addr[31:2];

  // With an empty FIFO an incoming store is written out straight from the inputs
  // while also becoming the new head entry.
  assign iss_addr = empty ? slv_itf.addr[31:2] : ent_addr[head_q];
  assign iss_mask = empty ? slv_itf.wmask      : ent_mask[head_q];
  assign iss_data = empty ? slv_itf.wdata      : ent_data[head_q];

  always_comb begin
    ld_match = 1'b0;
    offs     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = PW'(i) - head_q;
      if ((CW'(offs) < count_q) && (ent_addr[i] == ld_word)) ld_match = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    issue_rd = 1'b0;
    issue_wr = 1'b0;
    pop      = 1'b0;
    case (state_q)
      D_IDLE: begin
        if (ld_active && !ld_match) begin
          issue_rd = 1'b1;
          state_d  = D_RD;
        end else if (!empty || in_wr) begin
          issue_wr = 1'b1;
          state_d  = D_WR;
        end
      end
      D_WR: begin
        if (mst_itf.resp) begin
          pop     = 1'b1;
          state_d = D_IDLE;
        end
      end
      D_RD: begin
        if (mst_itf.resp) state_d = D_IDLE;
      end
      default: state_d = D_IDLE;
    endcase
  end

`ifdef WBUF_COALESCE_EN
  logic [PW-1:0] young_idx;
  assign young_idx = tail_q - PW'(1);
  // A lone entry is always the head being written out, so it must stay untouched.
  assign merge = in_wr && !empty && (ent_addr[young_idx] == slv_itf.addr[31:2]) &&
                 !((count_q == CW'(1)) && ((state_q == D_WR) || issue_wr));
`else
  assign merge = 1'b0;
`endif

  assign push_in = in_wr && !merge && (!full || pop);
  assign hold_in = in_wr && !merge && full && !pop;
  assign push_hw = hw_valid_q && pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= D_IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      rd_pend_q   <= 1'b0;
      rd_addr_q   <= '0;
      rd_mask_q   <= '0;
      hw_valid_q  <= 1'b0;
      hw_addr_q   <= '0;
      hw_mask_q   <= '0;
      hw_data_q   <= '0;
      ack_q       <= 1'b0;
      mst_addr_q  <= '0;
      mst_wdata_q <= '0;
      mst_rmask_q <= '0;
      mst_wmask_q <= '0;
    end else begin
      state_q <= state_d;
      if (pop) head_q <= head_q + PW'(1);
      if (push_in || push_hw) tail_q <= tail_q + PW'(1);
      count_q <= count_q + CW'(push_in || push_hw) - CW'(pop);
      ack_q   <= (in_wr && (merge || push_in)) || push_hw;

      if (issue_rd) rd_pend_q <= 1'b0;
      else if (in_rd) rd_pend_q <= 1'b1;
      if (in_rd) begin
        rd_addr_q <= slv_itf.addr;
        rd_mask_q <= slv_itf.rmask;
      end

      if (hold_in) begin
        hw_valid_q <= 1'b1;
        hw_addr_q  <= slv_itf.addr[31:2];
        hw_mask_q  <= slv_itf.wmask;
        hw_data_q  <= slv_itf.wdata;
      end else if (push_hw) begin
        hw_valid_q <= 1'b0;
      end

      mst_rmask_q <= issue_rd ? ld_mask : '0;
      mst_wmask_q <= issue_wr ? iss_mask : '0;
      mst_addr_q  <= issue_rd ? ld_addr : (issue_wr ? {iss_addr, 2'b00} : '0);
      mst_wdata_q <= issue_wr ? iss_data : '0;
    end
  end

  // Entry payload needs no reset: validity is carried entirely by head/count.
  always_ff @(posedge clk) begin
    if (push_in) begin
      ent_addr[tail_q] <= slv_itf.addr[31:2];
      ent_mask[tail_q] <= slv_itf.wmask;
      ent_data[tail_q] <= slv_itf.wdata;
    end else if (push_hw) begin
      ent_addr[tail_q] <= hw_addr_q;
      ent_mask[tail_q] <= hw_mask_q;
      ent_data[tail_q] <= hw_data_q;
    end
`ifdef WBUF_COALESCE_EN
    if (merge) begin
      ent_mask[young_idx] <= ent_mask[young_idx] | slv_itf.wmask;
      for (int b = 0; b < 4; b++) begin
        if (slv_itf.wmask[b]) ent_data[young_idx][8*b +: 8] <= slv_itf.wdata[8*b +: 8];
      end
    end
`endif
  end

  assign slv_itf.resp  = ack_q || ((state_q == D_RD) && mst_itf.resp);
  assign slv_itf.rdata = (state_q == D_RD) ? mst_itf.rdata : '0;

  assign mst_itf.addr  = mst_addr_q;
  assign mst_itf.rmask = mst_rmask_q;
  assign mst_itf.wmask = mst_wmask_q;
  assign mst_itf.wdata = mst_wdata_q;
endmodule

// File: tb/tb_dmem_wbuf.sv
// tb_dmem_wbuf: scoreboard bench for dmem_wbuf with a fixed-latency downstream memory model.
// Read data returned downstream is the request address XOR 32'h5A5A5A5A.
module tb_dmem_wbuf;
  logic clk = 1'b0;
  logic rst = 1'b1;

  dmem_itf slv_if();
  dmem_itf mst_if();

  dmem_wbuf #(.DEPTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .slv_itf(slv_if),
    .mst_itf(mst_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } mreq_t;

  typedef struct {
    bit          is_load;
    logic [31:0] rdata;
  } sresp_t;

  mreq_t  wr_q[$];
  mreq_t  rd_q[$];
  sresp_t slv_q[$];
  int     wr_cycles[$];
  int     rd_cycles[$];
  int     rd_wrcount[$];

  int          tests_run = 0;
  int          tests_failed = 0;
  int          cyc = 0;
  int          ds_lat = 3;
  logic [31:0] ds_addr;
  bit          ds_is_rd;
  mreq_t       mon_w;
  sresp_t      mon_s;

  logic [31:0] t2_addr [5] = '{32'h1100_0000, 32'h1100_0004, 32'h1100_0008,
                               32'h1100_000C, 32'h1100_0010};
  logic [31:0] t2_data [5] = '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003,
                               32'hA000_0004, 32'hA000_0005};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    mreq_t e;
    e.addr = a; e.mask = m; e.data = d;
    wr_q.push_back(e);
  endtask

  task automatic exp_slv_wr();
    sresp_t s;
    s.is_load = 1'b0; s.rdata = '0;
    slv_q.push_back(s);
  endtask

  task automatic exp_rd(input logic [31:0] a, input logic [3:0] m, input logic [31:0] rdata);
    mreq_t  e;
    sresp_t s;
    e.addr = a; e.mask = m; e.data = '0;
    rd_q.push_back(e);
    s.is_load = 1'b1; s.rdata = rdata;
    slv_q.push_back(s);
  endtask

  task automatic clear_marks();
    wr_cycles.delete();
    rd_cycles.delete();
    rd_wrcount.delete();
  endtask

  // Issue one upstream request and wait (bounded) for its resp; lat counts cycles after T.
  task automatic applyStimulus(input bit is_wr, input logic [31:0] a, input logic [3:0] m,
                               input logic [31:0] d, output int lat);
    slv_if.addr = a;
    if (is_wr) begin
      slv_if.wmask = m;
      slv_if.wdata = d;
    end else begin
      slv_if.rmask = m;
    end
    @(posedge clk);
    #1;
    slv_if.rmask = '0;
    slv_if.wmask = '0;
    lat = 1;
    @(negedge clk);
    while (!slv_if.resp && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!slv_if.resp) checkOutput("slv_resp_timeout", 0, 1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((wr_q.size() != 0 || rd_q.size() != 0 || slv_q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checkOutput({name, "_drain_timeout"}, 1, 0);
      wr_q.delete();
      rd_q.delete();
      slv_q.delete();
    end
    repeat (ds_lat + 4) @(negedge clk);
  endtask

  // Downstream memory: answers each request ds_lat cycles after it appears.
  initial begin
    mst_if.resp  = 1'b0;
    mst_if.rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && (mst_if.wmask != 0 || mst_if.rmask != 0)) begin
        ds_addr  = mst_if.addr;
        ds_is_rd = (mst_if.rmask != 0);
        repeat (ds_lat) @(posedge clk);
        #1;
        mst_if.resp  = 1'b1;
        mst_if.rdata = ds_is_rd ? (ds_addr ^ 32'h5A5A_5A5A) : 32'h0;
        @(posedge clk);
        #1;
        mst_if.resp  = 1'b0;
        mst_if.rdata = '0;
      end
    end
  end

  // Monitor: compares every presented DUT output against the scoreboard queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (mst_if.wmask != 0) begin
        wr_cycles.push_back(cyc);
        if (wr_q.size() == 0) begin
          checkOutput("mst_unexpected_wr", 1, 0);
        end else begin
          mon_w = wr_q.pop_front();
          checkOutput("mst_wr_addr", mst_if.addr, mon_w.addr);
          checkOutput("mst_wr_mask", mst_if.wmask, mon_w.mask);
          checkOutput("mst_wr_data", mst_if.wdata, mon_w.data);
        end
      end
      if (mst_if.rmask != 0) begin
        rd_cycles.push_back(cyc);
        rd_wrcount.push_back(wr_cycles.size());
        if (rd_q.size() == 0) begin
          checkOutput("mst_unexpected_rd", 1, 0);
        end else begin
          mon_w = rd_q.pop_front();
          checkOutput("mst_rd_addr", mst_if.addr, mon_w.addr);
          checkOutput("mst_rd_mask", mst_if.rmask, mon_w.mask);
        end
      end
      if (slv_if.resp) begin
        if (slv_q.size() == 0) begin
          checkOutput("slv_unexpected_resp", 1, 0);
        end else begin
          mon_s = slv_q.pop_front();
          if (mon_s.is_load) checkOutput("slv_rdata", slv_if.rdata, mon_s.rdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int t0;
    slv_if.addr  = '0;
    slv_if.rmask = '0;
    slv_if.wmask = '0;
    slv_if.wdata = '0;

    repeat (3) @(negedge clk);
    checkOutput("rst_mst_wmask", mst_if.wmask, 0);
    checkOutput("rst_mst_rmask", mst_if.rmask, 0);
    checkOutput("rst_mst_addr", mst_if.addr, 0);
    checkOutput("rst_mst_wdata", mst_if.wdata, 0);
    checkOutput("rst_slv_resp", slv_if.resp, 0);
    checkOutput("rst_slv_rdata", slv_if.rdata, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single store, written out the cycle after it is accepted.
    $display("[TB] single store");
    ds_lat = 3;
    clear_marks();
    exp_wr(32'h1000_0000, 4'hF, 32'hDEAD_BEEF);
    exp_slv_wr();
    t0 = cyc;
    applyStimulus(1'b1, 32'h1000_0000, 4'hF, 32'hDEAD_BEEF, lat);
    checkOutput("t1_ack_lat", lat, 1);
    wait_idle("t1");
    checkOutput("t1_wr_cycle", (wr_cycles.size() > 0) ? wr_cycles[0] : -1, t0 + 1);
    checkOutput("t1_wr_count", wr_cycles.size(), 1);

    // Five back-to-back stores overflow a 4-deep buffer.
    $display("[TB] buffer full");
    ds_lat = 4;
    clear_marks();
    for (int i = 0; i < 5; i++) begin
      exp_wr(t2_addr[i], 4'hF, t2_data[i]);
      exp_slv_wr();
      applyStimulus(1'b1, t2_addr[i], 4'hF, t2_data[i], lat);
      checkOutput($sformatf("t2_ack_lat%0d", i), lat, (i < 4) ? 1 : 2);
    end
    wait_idle("t2");
    checkOutput("t2_wr_count", wr_cycles.size(), 5);

    // Non-matching load overtakes the remaining drain.
    $display("[TB] load bypass");
    ds_lat = 4;
    clear_marks();
    exp_wr(32'h3000_0000, 4'hF, 32'hB000_0000); exp_slv_wr();
    applyStimulus(1'b1, 32'h3000_0000, 4'hF, 32'hB000_0000, lat);
    exp_wr(32'h3000_0010, 4'hF, 32'hB000_0010); exp_slv_wr();
    applyStimulus(1'b1, 32'h3000_0010, 4'hF, 32'hB000_0010, lat);
    exp_wr(32'h3000_0020, 4'hF, 32'hB000_0020); exp_slv_wr();
    applyStimulus(1'b1, 32'h3000_0020, 4'hF, 32'hB000_0020, lat);
    exp_rd(32'h3000_000C, 4'hF, 32'h6A5A_5A56);
    applyStimulus(1'b0, 32'h3000_000C, 4'hF, 32'h0, lat);
    checkOutput("t3_ld_lat", lat, 8);
    wait_idle("t3");
    checkOutput("t3_wr_before_rd", (rd_wrcount.size() > 0) ? rd_wrcount[0] : -1, 1);
    checkOutput("t3_wr_count", wr_cycles.size(), 3);

    // Load to an idle, empty buffer: minimum latency.
    $display("[TB] idle load");
    ds_lat = 2;
    clear_marks();
    exp_rd(32'h4000_0000, 4'hF, 32'h1A5A_5A5A);
    t0 = cyc;
    applyStimulus(1'b0, 32'h4000_0000, 4'hF, 32'h0, lat);
    checkOutput("t3b_ld_lat", lat, 3);
    wait_idle("t3b");
    checkOutput("t3b_rd_cycle", (rd_cycles.size() > 0) ? rd_cycles[0] : -1, t0 + 1);

    // Load hitting a buffered word waits for that entry to drain.
    $display("[TB] load conflict");
    ds_lat = 3;
    clear_marks();
    exp_wr(32'h2000_0004, 4'hF, 32'h1122_3344); exp_slv_wr();
    t0 = cyc;
    applyStimulus(1'b1, 32'h2000_0004, 4'hF, 32'h1122_3344, lat);
    exp_rd(32'h2000_0006, 4'h4, 32'h7A5A_5A5C);
    applyStimulus(1'b0, 32'h2000_0006, 4'h4, 32'h0, lat);
    checkOutput("t4_ld_lat", lat, 8);
    wait_idle("t4");
    checkOutput("t4_rd_cycle", (rd_cycles.size() > 0) ? rd_cycles[0] : -1, t0 + 6);
    checkOutput("t4_wr_before_rd", (rd_wrcount.size() > 0) ? rd_wrcount[0] : -1, 1);

    // Two partial stores to one word behind an unrelated head entry.
    $display("[TB] same-word stores");
    ds_lat = 3;
    clear_marks();
    exp_wr(32'h5000_0000, 4'hF, 32'hCAFE_F00D); exp_slv_wr();
`ifdef WBUF_COALESCE_EN
    exp_wr(32'h5000_0008, 4'hF, 32'h3333_2222);
    exp_slv_wr();
    exp_slv_wr();
`else
    exp_wr(32'h5000_0008, 4'h3, 32'h1111_2222);
    exp_wr(32'h5000_0008, 4'hC, 32'h3333_4444);
    exp_slv_wr();
    exp_slv_wr();
`endif
    applyStimulus(1'b1, 32'h5000_0000, 4'hF, 32'hCAFE_F00D, lat);
    applyStimulus(1'b1, 32'h5000_0008, 4'h3, 32'h1111_2222, lat);
    checkOutput("t5_ack_lat1", lat, 1);
    applyStimulus(1'b1, 32'h5000_0008, 4'hC, 32'h3333_4444, lat);
    checkOutput("t5_ack_lat2", lat, 1);
    wait_idle("t5");
`ifdef WBUF_COALESCE_EN
    checkOutput("t5_wr_count", wr_cycles.size(), 2);
`else
    checkOutput("t5_wr_count", wr_cycles.size(), 3);
`endif

    // Reset while a write is outstanding with two entries buffered.
    $display("[TB] reset mid-drain");
    ds_lat = 6;
    clear_marks();
    exp_wr(32'h6000_0000, 4'hF, 32'h6666_0000); exp_slv_wr();
    applyStimulus(1'b1, 32'h6000_0000, 4'hF, 32'h6666_0000, lat);
    exp_wr(32'h6000_0004, 4'hF, 32'h6666_0004); exp_slv_wr();
    applyStimulus(1'b1, 32'h6000_0004, 4'hF, 32'h6666_0004, lat);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("t6_mst_wmask", mst_if.wmask, 0);
    checkOutput("t6_mst_rmask", mst_if.rmask, 0);
    checkOutput("t6_mst_addr", mst_if.addr, 0);
    checkOutput("t6_mst_wdata", mst_if.wdata, 0);
    checkOutput("t6_slv_resp", slv_if.resp, 0);
    checkOutput("t6_slv_rdata", slv_if.rdata, 0);
    wr_q.delete();
    rd_q.delete();
    slv_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (15) @(negedge clk);
    checkOutput("t6_wr_count", wr_cycles.size(), 1);

    checkOutput("end_wr_q_empty", wr_q.size(), 0);
    checkOutput("end_slv_q_empty", slv_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
